// File: rtl/encoder_pkg.sv
// Shared types and sizing helpers for the synthetic encoder pulse generator.
package encoder_pkg;

  localparam int unsigned RATE_W = 32;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} enc_state_t;

  // Clocks per measurement window.
  function automatic int unsigned num_clocks(input int unsigned freq, input int unsigned rate);
    return freq / rate;
  endfunction

  // Highest rate that still leaves a full low phase between pulses.
  function automatic int unsigned max_rate(input int unsigned num_clks, input int unsigned high_clks);
    return num_clks / (2 * high_clks);
  endfunction

endpackage

// File: rtl/encoder_pulse_gen_if.sv
// Control/status bundle of encoder_pulse_gen; ENCODER_QUADRATURE_EN adds dir and encoder_b.
interface encoder_pulse_gen_if;
  import encoder_pkg::*;

  logic              enable;
  logic [RATE_W-1:0] rate_in;
  logic              rate_load;
  logic              encoder_out;
  logic              pulse_strobe;
  logic              window_tick;
  logic [RATE_W-1:0] rate_active;
  logic              rate_clamped;
`ifdef ENCODER_QUADRATURE_EN
  logic              dir;
  logic              encoder_b;

  modport master (
    output enable, rate_in, rate_load, dir,
    input  encoder_out, pulse_strobe, window_tick, rate_active, rate_clamped, encoder_b
  );
  modport slave (
    input  enable, rate_in, rate_load, dir,
    output encoder_out, pulse_strobe, window_tick, rate_active, rate_clamped, encoder_b
  );
`else
  modport master (
    output enable, rate_in, rate_load,
    input  encoder_out, pulse_strobe, window_tick, rate_active, rate_clamped
  );
  modport slave (
    input  enable, rate_in, rate_load,
    output encoder_out, pulse_strobe, window_tick, rate_active, rate_clamped
  );
`endif
endinterface

// File: rtl/pulse_shaper.sv
// Stretches a one-cycle fire into a HIGH_CLKS-wide high phase; busy mirrors the high phase.
module pulse_shaper #(
  parameter int unsigned HIGH_CLKS = 4
) (
  input  logic clock,
  input  logic system_reset,
  input  logic fire,
  output logic pulse,
  output logic busy
);

  localparam int unsigned HOLD_W = $clog2(HIGH_CLKS + 1);

  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              pulse_q;

  always_comb begin
    hold_d = hold_q;
    if (fire) begin
      hold_d = HOLD_W'(HIGH_CLKS);
    end else if (hold_q != '0) begin
      hold_d = hold_q - HOLD_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (system_reset) begin
      hold_q  <= '0;
      pulse_q <= 1'b0;
    end else begin
      hold_q  <= hold_d;
      pulse_q <= (hold_d != '0);
    end
  end

  assign pulse = pulse_q;
  assign busy  = pulse_q;

endmodule

// File: rtl/encoder_pulse_gen.sv
// Synthetic encoder: exactly rate_active evenly spread rising edges per window.
// Optional quadrature channel B under `ENCODER_QUADRATURE_EN.
module encoder_pulse_gen
  import encoder_pkg::*;
#(
  parameter int unsigned CLOCK_FREQ      = 100000000,
  parameter int unsigned PERCENT_SECOND  = 1000,
  parameter int unsigned PULSE_HIGH_CLKS = 4
) (
  input logic                clock,
  input logic                system_reset,
  encoder_pulse_gen_if.slave bus
);

  localparam int unsigned NUM_CLOCKS = num_clocks(CLOCK_FREQ, PERCENT_SECOND);
  localparam int unsigned MAX_RATE   = max_rate(NUM_CLOCKS, PULSE_HIGH_CLKS);
  localparam int unsigned CNT_W      = (NUM_CLOCKS > 1) ? $clog2(NUM_CLOCKS) : 1;
  localparam int unsigned SUM_W      = RATE_W + 1;
  localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(NUM_CLOCKS - 1);
  localparam logic [SUM_W-1:0]  SUM_N      = SUM_W'(NUM_CLOCKS);
  localparam logic [RATE_W-1:0] MAX_RATE_V = RATE_W'(MAX_RATE);

  enc_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [RATE_W-1:0] acc_q, acc_d, acc_base, rate_use;
  logic [RATE_W-1:0] rate_active_q, rate_active_d, pending_q;
  logic [SUM_W-1:0]  sum;
  logic              fire_c, tick_d, tick_q, strobe_q, clamped_q;
  logic              shp_pulse, shp_busy, busy;
`ifdef ENCODER_QUADRATURE_EN
  localparam int unsigned DLY = PULSE_HIGH_CLKS / 2;
  logic [DLY-1:0]    dly_q;
  logic              dir_q, dir_d;
`endif

  always_ff @(posedge clock) begin
    if (system_reset) state_q <= IDLE;
    else              state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.enable) state_d = RUN;
      RUN:     if (!bus.enable) state_d = busy ? DRAIN : IDLE;
      DRAIN:   if (!busy) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Work for a RUN cycle is done on the edge entering it, so outputs line up with its count.
  always_comb begin
    cnt_d         = cnt_q;
    acc_d         = acc_q;
    rate_active_d = rate_active_q;
    acc_base      = acc_q;
    rate_use      = rate_active_q;
    sum           = '0;
    fire_c        = 1'b0;
    tick_d        = 1'b0;
`ifdef ENCODER_QUADRATURE_EN
    dir_d         = dir_q;
`endif
    if (state_d == RUN) begin
      if (state_q != RUN || cnt_q == CNT_LAST) begin
        cnt_d         = '0;
        acc_base      = '0;
        rate_use      = pending_q;
        rate_active_d = pending_q;
`ifdef ENCODER_QUADRATURE_EN
        dir_d         = bus.dir;
`endif
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      sum = {1'b0, acc_base} + {1'b0, rate_use};
      if (sum >= SUM_N) begin
        fire_c = 1'b1;
        acc_d  = RATE_W'(sum - SUM_N);
      end else begin
        acc_d  = RATE_W'(sum);
      end
      tick_d = (cnt_d == CNT_LAST);
    end
  end

  always_ff @(posedge clock) begin
    if (system_reset) begin
      cnt_q         <= '0;
      acc_q         <= '0;
      rate_active_q <= '0;
      pending_q     <= '0;
      clamped_q     <= 1'b0;
      tick_q        <= 1'b0;
      strobe_q      <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      acc_q         <= acc_d;
      rate_active_q <= rate_active_d;
      tick_q        <= tick_d;
      strobe_q      <= fire_c;
      if (bus.rate_load) begin
        if (bus.rate_in > MAX_RATE_V) begin
          pending_q <= MAX_RATE_V;
          clamped_q <= 1'b1;
        end else begin
          pending_q <= bus.rate_in;
        end
      end
    end
  end

  pulse_shaper #(
    .HIGH_CLKS (PULSE_HIGH_CLKS)
  ) u_shaper (
    .clock        (clock),
    .system_reset (system_reset),
    .fire         (fire_c),
    .pulse        (shp_pulse),
    .busy         (shp_busy)
  );

`ifdef ENCODER_QUADRATURE_EN
  // Lagging copy of the shaped pulse; dir picks which pin leads.
  always_ff @(posedge clock) begin
    if (system_reset) begin
      dly_q <= '0;
      dir_q <= 1'b0;
    end else begin
      dly_q <= DLY'({dly_q, shp_pulse});
      dir_q <= dir_d;
    end
  end

  assign busy            = shp_busy | (|dly_q);
  assign bus.encoder_out = dir_q ? dly_q[DLY-1] : shp_pulse;
  assign bus.encoder_b   = dir_q ? shp_pulse : dly_q[DLY-1];
`else
  assign busy            = shp_busy;
  assign bus.encoder_out = shp_pulse;
`endif

  assign bus.pulse_strobe = strobe_q;
  assign bus.window_tick  = tick_q;
  assign bus.rate_active  = rate_active_q;
  assign bus.rate_clamped = clamped_q;

endmodule

// File: tb/tb_encoder_pulse_gen.sv
// Bench for encoder_pulse_gen: window tables, directed corner cases and a random run vs a reference model.
module tb_encoder_pulse_gen;

  localparam int N    = 100;
  localparam int H    = 2;
  localparam int MAXR = 25;

  logic clock = 1'b0;
  logic system_reset = 1'b1;
  always #5 clock = ~clock;

  encoder_pulse_gen_if bus ();

  encoder_pulse_gen #(
    .CLOCK_FREQ      (1000),
    .PERCENT_SECOND  (10),
    .PULSE_HIGH_CLKS (2)
  ) dut (
    .clock        (clock),
    .system_reset (system_reset),
    .bus          (bus)
  );

  int total = 0;
  int bad   = 0;
  bit chk_on = 1'b0;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: edge k of a window with rate r falls on count c where floor((c+1)r/N) > floor(cr/N).
  bit     m_run, m_drain, m_clamp, m_strobe, m_tick;
  int     m_cnt, m_high;
  longint m_rate, m_pend;

  always @(posedge clock) begin
    bit en, ld, rs, fire, old_hi;
    longint ri;
    en = bus.enable; ld = bus.rate_load; ri = bus.rate_in; rs = system_reset;
    if (rs) begin
      m_run = 0; m_drain = 0; m_clamp = 0; m_strobe = 0; m_tick = 0;
      m_cnt = 0; m_high = 0; m_rate = 0; m_pend = 0;
    end else begin
      old_hi = (m_high > 0);
      fire = 0;
      m_tick = 0;
      if (en && (m_run || !m_drain)) begin
        if (!m_run || m_cnt == N - 1) begin
          m_cnt = 0;
          m_rate = m_pend;
        end else begin
          m_cnt++;
        end
        m_run = 1;
        fire = (((m_cnt + 1) * m_rate) / N) > ((m_cnt * m_rate) / N);
        m_tick = (m_cnt == N - 1);
      end else if (m_run) begin
        m_run = 0;
        m_drain = old_hi;
      end else if (m_drain && !old_hi) begin
        m_drain = 0;
      end
      m_strobe = fire;
      if (fire) m_high = H;
      else if (m_high > 0) m_high--;
      if (ld) begin
        m_pend = (ri > MAXR) ? MAXR : ri;
        if (ri > MAXR) m_clamp = 1;
      end
    end
    #1;
    if (chk_on) begin
      check("m_strobe", bus.pulse_strobe, m_strobe);
      check("m_enc", bus.encoder_out, (m_high > 0));
      check("m_tick", bus.window_tick, m_tick);
      check("m_rate_active", bus.rate_active, m_rate);
      check("m_clamped", bus.rate_clamped, m_clamp);
    end
  end

  task automatic cyc();
    @(negedge clock);
  endtask

  task automatic do_reset();
    system_reset = 1'b1;
    bus.enable = 1'b0;
    bus.rate_load = 1'b0;
    cyc();
    system_reset = 1'b0;
  endtask

  task automatic load(input int v);
    bus.rate_in = 32'(v);
    bus.rate_load = 1'b1;
    cyc();
    bus.rate_load = 1'b0;
  endtask

  // Observes one 100-clock window; optional load issued after sampling count load_at.
  task automatic measure(input int load_at, input int load_val,
                         output int strobes, output int rises, output int tick_pos,
                         output int highs, output longint ra_first, output longint ra_last,
                         output int min_gap);
    int last_s;
    bit prev;
    strobes = 0; rises = 0; tick_pos = -1; highs = 0; last_s = -1; min_gap = 1000;
    ra_first = 0; ra_last = 0;
    prev = bus.encoder_out;
    for (int i = 0; i < N; i++) begin
      cyc();
      if (bus.pulse_strobe) begin
        strobes++;
        if (last_s >= 0 && (i - last_s) < min_gap) min_gap = i - last_s;
        last_s = i;
      end
      if (bus.encoder_out && !prev) rises++;
      prev = bus.encoder_out;
      if (bus.encoder_out) highs++;
      if (bus.window_tick) tick_pos = i;
      if (i == 0) ra_first = bus.rate_active;
      if (i == N - 1) ra_last = bus.rate_active;
      if (i == load_at) begin
        bus.rate_in = 32'(load_val);
        bus.rate_load = 1'b1;
      end else begin
        bus.rate_load = 1'b0;
      end
    end
    bus.rate_load = 1'b0;
  endtask

  task automatic wait_strobe(output bit found);
    found = 0;
    for (int k = 0; k < 200 && !found; k++) begin
      cyc();
      if (bus.pulse_strobe) found = 1;
    end
  endtask

  typedef struct {
    int rate_in;
    int exp_active;
    int exp_edges;
    bit exp_clamp;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int s, r, tp, hi, gap, quiet;
    longint raf, ral;
    bit found;

    bus.enable = 1'b0;
    bus.rate_in = '0;
    bus.rate_load = 1'b0;
`ifdef ENCODER_QUADRATURE_EN
    bus.dir = 1'b0;
`endif
    vecs[0] = '{10, 10, 10, 1'b0};
    vecs[1] = '{0, 0, 0, 1'b0};
    vecs[2] = '{25, 25, 25, 1'b0};
    vecs[3] = '{30, 25, 25, 1'b1};
    vecs[4] = '{1, 1, 1, 1'b0};
    vecs[5] = '{26, 25, 25, 1'b1};

    cyc();
    system_reset = 1'b0;
    chk_on = 1'b1;
    check("reset_enc", bus.encoder_out, 0);
    check("reset_rate_active", bus.rate_active, 0);

    foreach (vecs[v]) begin
      do_reset();
      load(vecs[v].rate_in);
      bus.enable = 1'b1;
      measure(-1, 0, s, r, tp, hi, raf, ral, gap);
      check("tbl_rate_active", raf, vecs[v].exp_active);
      check("tbl_strobes", s, vecs[v].exp_edges);
      check("tbl_rises", r, vecs[v].exp_edges);
      check("tbl_tick_pos", tp, N - 1);
      check("tbl_clamped", bus.rate_clamped, vecs[v].exp_clamp);
      if (s > 1) check("tbl_spacing_ok", (gap >= 2 * H), 1);
    end

    // Rate 10: edges 10 apart, 2-clock highs; second window inherits the straddling high.
    do_reset();
    load(10);
    bus.enable = 1'b1;
    measure(-1, 0, s, r, tp, hi, raf, ral, gap);
    check("r10_gap", gap, 10);
    check("r10_highs_w1", hi, 19);
    measure(-1, 0, s, r, tp, hi, raf, ral, gap);
    check("r10_strobes_w2", s, 10);
    check("r10_highs_w2", hi, 20);

    // Mid-window load takes effect next window.
    do_reset();
    load(5);
    bus.enable = 1'b1;
    measure(40, 20, s, r, tp, hi, raf, ral, gap);
    check("ml_strobes_w1", s, 5);
    check("ml_ra_tick", ral, 5);
    measure(-1, 0, s, r, tp, hi, raf, ral, gap);
    check("ml_ra_w2", raf, 20);
    check("ml_strobes_w2", s, 20);

    // Clamp is sticky across a later in-range load.
    do_reset();
    load(30);
    bus.enable = 1'b1;
    measure(50, 10, s, r, tp, hi, raf, ral, gap);
    check("cl_ra_w1", raf, 25);
    check("cl_strobes_w1", s, 25);
    measure(-1, 0, s, r, tp, hi, raf, ral, gap);
    check("cl_ra_w2", raf, 10);
    check("cl_strobes_w2", s, 10);
    check("cl_sticky", bus.rate_clamped, 1);

    // Enable dropped on first high cycle: pulse completes, then quiet.
    do_reset();
    load(10);
    bus.enable = 1'b1;
    wait_strobe(found);
    check("drop_found", found, 1);
    check("drop_enc_hi0", bus.encoder_out, 1);
    bus.enable = 1'b0;
    cyc();
    check("drop_enc_hi1", bus.encoder_out, 1);
    cyc();
    check("drop_enc_lo", bus.encoder_out, 0);
    quiet = 0;
    for (int i = 0; i < 150; i++) begin
      cyc();
      quiet += int'(bus.encoder_out) + int'(bus.pulse_strobe) + int'(bus.window_tick);
    end
    check("drop_quiet", quiet, 0);
    bus.enable = 1'b1;
    measure(-1, 0, s, r, tp, hi, raf, ral, gap);
    check("drop_restart", s, 10);
    check("drop_restart_tick", tp, N - 1);

    // Reset taken mid-pulse.
    do_reset();
    load(30);
    bus.enable = 1'b1;
    wait_strobe(found);
    check("rst_found", found, 1);
    system_reset = 1'b1;
    cyc();
    check("rst_enc", bus.encoder_out, 0);
    check("rst_rate_active", bus.rate_active, 0);
    check("rst_clamped", bus.rate_clamped, 0);
    system_reset = 1'b0;
    bus.enable = 1'b0;

    // Random enable/load/reset activity against the reference model.
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 59) == 0) bus.enable = ~bus.enable;
      if ($urandom_range(0, 39) == 0) begin
        bus.rate_in = 32'($urandom_range(0, 40));
        bus.rate_load = 1'b1;
      end else begin
        bus.rate_load = 1'b0;
      end
      system_reset = ($urandom_range(0, 1499) == 0);
      cyc();
    end
    system_reset = 1'b0;
    cyc();
    chk_on = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/encoder_pulse_gen.md
Name: encoder_pulse_gen

Overview:
- Synthetic motor-encoder source: emits a pulse train with an exact, programmable number of rising edges per measurement window.
- Windows are CLOCK_FREQ/PERCENT_SECOND clocks long, the same window the tachometer counts over.
- Used to close the loop on the tachometer and speed-control logic in simulation and on the board without a motor attached.
- Pulse spacing uses a Bresenham accumulator, so edges are spread evenly across the window rather than bunched.

Parameters:
- CLOCK_FREQ, 100000000: system clock frequency, Hz.
- PERCENT_SECOND, 1000: windows per second. Localparam NUM_CLOCKS = CLOCK_FREQ/PERCENT_SECOND.
- PULSE_HIGH_CLKS, 4: high time of each output pulse in clocks, ≥2. Localparam MAX_RATE = NUM_CLOCKS/(2*PULSE_HIGH_CLKS).

Ports:
- clock  input  1  system clock.
- system_reset  input  1  synchronous, active-high reset.
- enable  input  1  level; 1 = generate pulses.
- rate_in  input  32  requested rising edges per window.
- rate_load  input  1  one-cycle strobe; captures rate_in into the pending register.
- encoder_out  output  1  synthetic encoder channel A.
- pulse_strobe  output  1  one-cycle pulse coincident with each encoder_out rising edge.
- window_tick  output  1  one-cycle pulse on the last clock of each window.
- rate_active  output  32  rate governing the current window.
- rate_clamped  output  1  sticky; set when a loaded rate exceeded MAX_RATE.

Behaviour:
- Clock and reset: one clock domain. Reset is synchronous, active-high.
- Reset values: encoder_out, pulse_strobe, window_tick, rate_clamped = 0; rate_active = 0; pending = 0; window counter, accumulator and hold counter = 0; FSM = IDLE.
- Reset taken mid-pulse: encoder_out is 0 on the cycle after reset is sampled. No pulse completion.
- rate_load: pending <= min(rate_in, MAX_RATE).
  - If rate_in > MAX_RATE, rate_clamped <= 1. It clears only on reset.
  - rate_load during IDLE: pending is still updated.
- FSM states:
  - IDLE → RUN when enable=1. The window counter and accumulator clear, and rate_active <= pending on that transition.
  - RUN → DRAIN when enable=0 and encoder_out=1.
  - RUN → IDLE when enable=0 and encoder_out=0.
  - DRAIN → IDLE when the hold count expires. DRAIN never starts a new pulse; there are no runt pulses.
- Window: the counter runs 0..NUM_CLOCKS-1 in RUN. window_tick=1 when count == NUM_CLOCKS-1.
  - On the following cycle: count <= 0, accumulator <= 0, rate_active <= pending.
  - A rate_load on the tick cycle itself takes effect in the next window.
- Pulse generation (RUN), each clock:
  - sum = acc + rate_active, computed at 33 bits.
  - If sum ≥ NUM_CLOCKS: acc <= sum − NUM_CLOCKS and fire; else acc <= sum.
  - Result: exactly rate_active fires per window. The last fire lands on count NUM_CLOCKS-1 when rate_active>0.
  - rate_active=0: no fires.
- Fire: pulse_strobe=1 and encoder_out rises on the same cycle, high for exactly PULSE_HIGH_CLKS clocks, then low.
  - The clamp guarantees spacing ≥ 2*PULSE_HIGH_CLKS, so fires never overlap a high phase.
  - A high phase may straddle a window boundary; the rising edge belongs to the window it fired in.
- Latency: rate_load to effect = up to one window plus 1 clock. Enable to first possible fire = 1 clock.

Optional Feature:
- Macro: ENCODER_QUADRATURE_EN.
- When defined:
  - Adds input dir (1 bit) and output encoder_b (1 bit); encoder_b resets to 0.
  - dir=0: encoder_b = encoder_out delayed by PULSE_HIGH_CLKS/2 clocks (B lags A).
  - dir=1: the channels swap, so A is the delayed copy and B the leading one.
  - dir is sampled only at window start.
  - pulse_strobe always marks the rising edge of the leading channel.
- When undefined: encoder_b, dir and the delay line do not exist; encoder_out behaves exactly as specified above.

Decomposition:
- Package encoder_pkg holds:
  - typedef enum {IDLE, RUN, DRAIN} enc_state_t;
  - function num_clocks(freq, rate);
  - function max_rate(num_clocks, high_clks).
- Sub-module pulse_shaper: input fire; output a PULSE_HIGH_CLKS-wide high; busy flag drives DRAIN exit.

Test Plan (bench params CLOCK_FREQ=1000, PERCENT_SECOND=10 → NUM_CLOCKS=100; PULSE_HIGH_CLKS=2 → MAX_RATE=25):
- Rate 10, then enable → exactly 10 rising edges per 100-clock window, each 2 clocks wide, consecutive edges 10 clocks apart, 10 pulse_strobes per window.
- Rate 0 → encoder_out stays 0; window_tick still pulses every 100 clocks.
- Rate 5 running, rate_load 20 at count 40 → current window 5 edges, next window 20 edges; rate_active changes the cycle after window_tick.
- rate_load with rate_in=30 → rate_active=25 next window, rate_clamped=1 and stays 1 after a later load of 10.
- enable dropped on the first high cycle of a pulse → encoder_out stays high 1 more clock, then FSM reaches IDLE; no further edges.
- system_reset asserted mid-pulse → encoder_out=0, rate_active=0, rate_clamped=0 on the next cycle.
